program_counter: RTL and testbench

//   Program-counter register with next-PC selection for the single-cycle MIPS datapath.

---
 rtl/program_counter_if.sv | 21 ++
 rtl/program_counter.sv | 42 ++++
 tb/tb_program_counter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/program_counter_if.sv
// Bundles the next-PC control inputs, operand inputs and the registered PC output.
// The datapath drives the master side; the program counter is the slave.
interface program_counter_if;
  logic        Jump;
  logic        Branch;
  logic        Zero;
  logic [25:0] dirJump_address;
  logic [31:0] pcIn;
  logic [31:0] extendedBits;
  logic [31:0] pcOut;

  modport master (
    output Jump, Branch, Zero, dirJump_address, pcIn, extendedBits,
    input  pcOut
  );

  modport slave (
    input  Jump, Branch, Zero, dirJump_address, pcIn, extendedBits,
    output pcOut
  );
endinterface

// File: rtl/program_counter.sv
// Single-cycle MIPS program counter: picks jump, taken-branch or PC+4 as the next
// address and registers it; pcOut is fed back externally as pcIn.
module program_counter #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  program_counter_if.slave  bus
);

  logic [31:0] pc_plus4;
  logic [31:0] br_target;
  logic [31:0] jmp_target;
  logic [31:0] pc_d;
  logic [31:0] pc_q;

  assign pc_plus4   = bus.pcIn + 32'd4;
  assign br_target  = pc_plus4 + {bus.extendedBits[29:0], 2'b00};
  // Region nibble comes from pc_plus4 so a jump in the last slot of a region lands in the next one.
  assign jmp_target = {pc_plus4[31:28], bus.dirJump_address, 2'b00};

  // Priority if/else keeps an unknown unused operand from leaking into the chosen path.
  always_comb begin
    pc_d = pc_plus4;
    if (bus.Jump) begin
      pc_d = jmp_target;
    end else if (bus.Branch && bus.Zero) begin
      pc_d = br_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign bus.pcOut = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// Directed self-checking bench for program_counter: one task per scenario,
// each comparing pcOut one cycle after driving its inputs.
module tb_program_counter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  program_counter_if bus ();

  program_counter #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic j, input logic b, input logic z,
                       input logic [25:0] ja, input logic [31:0] pc,
                       input logic [31:0] ext);
    bus.Jump            = j;
    bus.Branch          = b;
    bus.Zero            = z;
    bus.dirJump_address = ja;
    bus.pcIn            = pc;
    bus.extendedBits    = ext;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 26'h0, 32'h0000_1234, 32'h0);
    tick();
    checks++;
    if (bus.pcOut !== 32'h0000_0000) begin
      $display("FAIL reset_load: pcOut=%h expected=%h", bus.pcOut, 32'h0000_0000);
      errors++;
    end else $display("reset_load: pcOut=%h", bus.pcOut);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 26'h0, 32'h0000_1234, 32'h0);
    tick();
    checks++;
    if (bus.pcOut !== 32'h0000_1238) begin
      $display("FAIL reset_release: pcOut=%h expected=%h", bus.pcOut, 32'h0000_1238);
      errors++;
    end else $display("reset_release: pcOut=%h", bus.pcOut);
  endtask

  task automatic test_sequential;
    logic [31:0] pc_tab  [4] = '{32'h0040_0000, 32'hFFFF_FFFC, 32'h0040_0001, 32'h7FFF_FFFE};
    logic [31:0] exp_tab [4] = '{32'h0040_0004, 32'h0000_0000, 32'h0040_0005, 32'h8000_0002};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b0, 26'h0, pc_tab[i], 32'h0);
      tick();
      checks++;
      if (bus.pcOut !== exp_tab[i]) begin
        $display("FAIL sequential[%0d]: pcOut=%h expected=%h", i, bus.pcOut, exp_tab[i]);
        errors++;
      end else $display("sequential[%0d]: pcOut=%h", i, bus.pcOut);
    end
  endtask

  task automatic test_branch_taken;
    logic [31:0] pc_tab  [4] = '{32'h0040_0010, 32'h0040_0010, 32'h0040_0002, 32'h0000_0100};
    logic [31:0] ext_tab [4] = '{32'h0000_0003, 32'hFFFF_FFFE, 32'h0000_0001, 32'hC000_0001};
    logic [31:0] exp_tab [4] = '{32'h0040_0020, 32'h0040_000C, 32'h0040_000A, 32'h0000_0108};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b1, 26'h0, pc_tab[i], ext_tab[i]);
      tick();
      checks++;
      if (bus.pcOut !== exp_tab[i]) begin
        $display("FAIL branch_taken[%0d]: pcOut=%h expected=%h", i, bus.pcOut, exp_tab[i]);
        errors++;
      end else $display("branch_taken[%0d]: pcOut=%h", i, bus.pcOut);
    end
  endtask

  task automatic test_branch_not_taken;
    logic b_tab [2] = '{1'b1, 1'b0};
    logic z_tab [2] = '{1'b0, 1'b1};
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, b_tab[i], z_tab[i], 26'h0, 32'h0040_0010, 32'h0000_0010);
      tick();
      checks++;
      if (bus.pcOut !== 32'h0040_0014) begin
        $display("FAIL branch_not_taken[%0d]: pcOut=%h expected=%h", i, bus.pcOut, 32'h0040_0014);
        errors++;
      end else $display("branch_not_taken[%0d]: pcOut=%h", i, bus.pcOut);
    end
  endtask

  task automatic test_jump;
    logic bz_tab [2] = '{1'b0, 1'b1};
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, bz_tab[i], bz_tab[i], 26'h010_0000, 32'h9000_0000, 32'h0000_0007);
      tick();
      checks++;
      if (bus.pcOut !== 32'h9040_0000) begin
        $display("FAIL jump[%0d]: pcOut=%h expected=%h", i, bus.pcOut, 32'h9040_0000);
        errors++;
      end else $display("jump[%0d]: pcOut=%h", i, bus.pcOut);
    end
  endtask

  task automatic test_jump_region;
    drive(1'b1, 1'b0, 1'b0, 26'h3FF_FFFF, 32'h0FFF_FFFC, 32'h0);
    tick();
    checks++;
    if (bus.pcOut !== 32'h1FFF_FFFC) begin
      $display("FAIL jump_region: pcOut=%h expected=%h", bus.pcOut, 32'h1FFF_FFFC);
      errors++;
    end else $display("jump_region: pcOut=%h", bus.pcOut);
    drive(1'b1, 1'b0, 1'b0, 26'h000_0001, 32'h0000_0003, 32'h0);
    tick();
    checks++;
    if (bus.pcOut !== 32'h0000_0004) begin
      $display("FAIL jump_align: pcOut=%h expected=%h", bus.pcOut, 32'h0000_0004);
      errors++;
    end else $display("jump_align: pcOut=%h", bus.pcOut);
  endtask

  task automatic test_unused_x;
    drive(1'b0, 1'b0, 1'b0, 26'hx, 32'h0000_0200, 32'hx);
    tick();
    checks++;
    if (bus.pcOut !== 32'h0000_0204) begin
      $display("FAIL x_seq: pcOut=%h expected=%h", bus.pcOut, 32'h0000_0204);
      errors++;
    end else $display("x_seq: pcOut=%h", bus.pcOut);
    drive(1'b0, 1'b1, 1'b0, 26'hx, 32'h0000_0300, 32'hx);
    tick();
    checks++;
    if (bus.pcOut !== 32'h0000_0304) begin
      $display("FAIL x_branch_nt: pcOut=%h expected=%h", bus.pcOut, 32'h0000_0304);
      errors++;
    end else $display("x_branch_nt: pcOut=%h", bus.pcOut);
    drive(1'b1, 1'b0, 1'b0, 26'h000_0040, 32'h3000_0000, 32'hx);
    tick();
    checks++;
    if (bus.pcOut !== 32'h3000_0100) begin
      $display("FAIL x_jump: pcOut=%h expected=%h", bus.pcOut, 32'h3000_0100);
      errors++;
    end else $display("x_jump: pcOut=%h", bus.pcOut);
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_pc;
    exp_pc = 32'h0000_0000;
    drive(1'b0, 1'b1, 1'b1, 26'h0, 32'h0040_0000, 32'h0000_0004);
    tick();
    exp_pc = 32'h0040_0014;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.pcOut !== exp_pc) begin
        $display("FAIL back_to_back[%0d]: pcOut=%h expected=%h", i, bus.pcOut, exp_pc);
        errors++;
      end else $display("back_to_back[%0d]: pcOut=%h", i, bus.pcOut);
      drive(1'b0, 1'b0, 1'b0, 26'h0, bus.pcOut, 32'h0);
      tick();
      exp_pc = exp_pc + 32'd4;
    end
    // Reset asserted mid-stream with a taken branch pending must still win.
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 26'h0, 32'h0040_0020, 32'h0000_0010);
    tick();
    checks++;
    if (bus.pcOut !== 32'h0000_0000) begin
      $display("FAIL midstream_reset: pcOut=%h expected=%h", bus.pcOut, 32'h0000_0000);
      errors++;
    end else $display("midstream_reset: pcOut=%h", bus.pcOut);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 26'h0, bus.pcOut, 32'h0);
    tick();
    checks++;
    if (bus.pcOut !== 32'h0000_0004) begin
      $display("FAIL post_reset_step: pcOut=%h expected=%h", bus.pcOut, 32'h0000_0004);
      errors++;
    end else $display("post_reset_step: pcOut=%h", bus.pcOut);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 26'h0, 32'h0, 32'h0);
    test_reset();
    test_sequential();
    test_branch_taken();
    test_branch_not_taken();
    test_jump();
    test_jump_region();
    test_unused_x();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
